// File: rtl/hwpe_stream_split_sched_pkg.sv
// rtl/hwpe_stream_split_sched_pkg.sv - shared types and capture-mask helper for the split scheduler
package hwpe_stream_split_sched_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    DIST = 1'b1
  } split_sched_state_e;

  localparam int unsigned STRB_SLICE_MAX = 64;

  // A slice is presented unless empty-skipping is on and none of its bytes are strobed.
  function automatic logic capture_bit(input logic skip_empty,
                                       input logic [STRB_SLICE_MAX-1:0] strb_slice);
    return !skip_empty || (|strb_slice);
  endfunction

endpackage

// File: rtl/hwpe_stream_split_slot.sv
// rtl/hwpe_stream_split_slot.sv - one output slice: holding register, pending flag, handshake detect
module hwpe_stream_split_slot
  import hwpe_stream_split_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned STRB_WIDTH = 4,
  parameter int unsigned SKIP_EMPTY = 1
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  clear_i,
  input  logic                  capture_i,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic [STRB_WIDTH-1:0] strb_i,
  input  logic                  pop_ready_i,
  output logic                  pop_valid_o,
  output logic [DATA_WIDTH-1:0] pop_data_o,
  output logic [STRB_WIDTH-1:0] pop_strb_o,
  output logic                  pending_o,
  output logic                  done_now_o,
  output logic                  capture_mask_o
);

  logic                      pending_q, pending_d;
  logic [DATA_WIDTH-1:0]     data_q, data_d;
  logic [STRB_WIDTH-1:0]     strb_q, strb_d;
  logic [STRB_SLICE_MAX-1:0] strb_ext;

  always_comb begin
    strb_ext = '0;
    strb_ext[STRB_WIDTH-1:0] = strb_i;
  end

  assign capture_mask_o = capture_bit(SKIP_EMPTY != 0, strb_ext);
  assign done_now_o     = pending_q & pop_ready_i;

  // A capture only happens once this slot is free or finishing this cycle, so it may overwrite.
  always_comb begin
    pending_d = pending_q;
    data_d    = data_q;
    strb_d    = strb_q;
    if (clear_i) begin
      pending_d = 1'b0;
      data_d    = '0;
      strb_d    = '0;
    end else if (capture_i) begin
      pending_d = capture_mask_o;
      data_d    = data_i;
      strb_d    = strb_i;
    end else if (done_now_o) begin
      pending_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      pending_q <= 1'b0;
      data_q    <= '0;
      strb_q    <= '0;
    end else begin
      pending_q <= pending_d;
      data_q    <= data_d;
      strb_q    <= strb_d;
    end
  end

  assign pop_valid_o = pending_q;
  assign pop_data_o  = data_q;
  assign pop_strb_o  = strb_q;
  assign pending_o   = pending_q;

endmodule

// File: rtl/hwpe_stream_split_sched.sv
// rtl/hwpe_stream_split_sched.sv - wide-to-narrow split with independent per-slice delivery
module hwpe_stream_split_sched
  import hwpe_stream_split_sched_pkg::*;
#(
  parameter int unsigned DATA_WIDTH_IN  = 128,
  parameter int unsigned NB_OUT_STREAMS = 4,
  parameter int unsigned SKIP_EMPTY     = 1,
  parameter int unsigned CNT_WIDTH      = 16,
  localparam int unsigned DATA_WIDTH_OUT = DATA_WIDTH_IN / NB_OUT_STREAMS,
  localparam int unsigned STRB_WIDTH_IN  = DATA_WIDTH_IN / 8,
  localparam int unsigned STRB_WIDTH_OUT = DATA_WIDTH_OUT / 8
) (
  input  logic                                     clk_i,
  input  logic                                     rst_i,
  input  logic                                     clear_i,
  input  logic                                     push_valid_i,
  output logic                                     push_ready_o,
  input  logic [DATA_WIDTH_IN-1:0]                 push_data_i,
  input  logic [STRB_WIDTH_IN-1:0]                 push_strb_i,
  output logic [NB_OUT_STREAMS-1:0]                pop_valid_o,
  input  logic [NB_OUT_STREAMS-1:0]                pop_ready_i,
  output logic [NB_OUT_STREAMS*DATA_WIDTH_OUT-1:0] pop_data_o,
  output logic [NB_OUT_STREAMS*STRB_WIDTH_OUT-1:0] pop_strb_o,
  output logic [NB_OUT_STREAMS-1:0]                pending_o,
  output logic                                     busy_o,
  output logic [CNT_WIDTH-1:0]                     beat_count_o
);

  split_sched_state_e        state_q, state_d;
  logic [CNT_WIDTH-1:0]      beat_count_q, beat_count_d;
  logic [NB_OUT_STREAMS-1:0] pending, done_now, capture_mask;
  logic                      capture, slices_clear, last_delivery, empty_capture;
  logic [1:0]                beat_inc;

  for (genvar i = 0; i < NB_OUT_STREAMS; i++) begin : gen_slot
    hwpe_stream_split_slot #(
      .DATA_WIDTH (DATA_WIDTH_OUT),
      .STRB_WIDTH (STRB_WIDTH_OUT),
      .SKIP_EMPTY (SKIP_EMPTY)
    ) i_slot (
      .clk_i          (clk_i),
      .rst_i          (rst_i),
      .clear_i        (clear_i),
      .capture_i      (capture),
      .data_i         (push_data_i[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
      .strb_i         (push_strb_i[i*STRB_WIDTH_OUT +: STRB_WIDTH_OUT]),
      .pop_ready_i    (pop_ready_i[i]),
      .pop_valid_o    (pop_valid_o[i]),
      .pop_data_o     (pop_data_o[i*DATA_WIDTH_OUT +: DATA_WIDTH_OUT]),
      .pop_strb_o     (pop_strb_o[i*STRB_WIDTH_OUT +: STRB_WIDTH_OUT]),
      .pending_o      (pending[i]),
      .done_now_o     (done_now[i]),
      .capture_mask_o (capture_mask[i])
    );
  end

  // Every still-pending slice handshakes this cycle, so the holding register frees up now.
  assign slices_clear  = (pending & ~pop_ready_i) == '0;
  assign push_ready_o  = !clear_i && ((state_q == IDLE) || slices_clear);
  assign capture       = push_valid_i && push_ready_o;
  assign last_delivery = (state_q == DIST) && slices_clear && !clear_i;
  assign empty_capture = capture && (capture_mask == '0);
  assign beat_inc      = {1'b0, last_delivery} + {1'b0, empty_capture};

  always_comb begin
    state_d      = state_q;
    beat_count_d = beat_count_q + CNT_WIDTH'(beat_inc);
    if (clear_i) begin
      state_d      = IDLE;
      beat_count_d = '0;
    end else if (capture) begin
      state_d = empty_capture ? IDLE : DIST;
    end else if (last_delivery) begin
      state_d = IDLE;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q      <= IDLE;
      beat_count_q <= '0;
    end else begin
      state_q      <= state_d;
      beat_count_q <= beat_count_d;
    end
  end

  assign pending_o    = pending;
  assign busy_o       = (state_q == DIST);
  assign beat_count_o = beat_count_q;

endmodule

// File: tb/tb_hwpe_stream_split_sched.sv
// tb/tb_hwpe_stream_split_sched.sv - directed vector bench for hwpe_stream_split_sched
module tb_hwpe_stream_split_sched;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         clear_i;
  logic         push_valid_i;
  logic         push_ready_o;
  logic [127:0] push_data_i;
  logic [15:0]  push_strb_i;
  logic [3:0]   pop_valid_o;
  logic [3:0]   pop_ready_i;
  logic [127:0] pop_data_o;
  logic [15:0]  pop_strb_o;
  logic [3:0]   pending_o;
  logic         busy_o;
  logic [1:0]   beat_count_o;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk_i = ~clk_i;

  hwpe_stream_split_sched #(
    .DATA_WIDTH_IN  (128),
    .NB_OUT_STREAMS (4),
    .SKIP_EMPTY     (1),
    .CNT_WIDTH      (2)
  ) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .clear_i      (clear_i),
    .push_valid_i (push_valid_i),
    .push_ready_o (push_ready_o),
    .push_data_i  (push_data_i),
    .push_strb_i  (push_strb_i),
    .pop_valid_o  (pop_valid_o),
    .pop_ready_i  (pop_ready_i),
    .pop_data_o   (pop_data_o),
    .pop_strb_o   (pop_strb_o),
    .pending_o    (pending_o),
    .busy_o       (busy_o),
    .beat_count_o (beat_count_o)
  );

  typedef struct {
    logic        pv;
    logic [15:0] strb;
    logic [3:0]  rdy;
    logic        exp_pr;
    logic [3:0]  exp_pend;
    logic        exp_busy;
    logic [1:0]  exp_cnt;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [127:0] pat(input int k);
    logic [127:0] w;
    for (int i = 0; i < 4; i++) w[i*32 +: 32] = 32'hA000_0000 | (32'(k) << 8) | 32'(i);
    return w;
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  logic [127:0] exp_data, slice2_data;
  logic [15:0]  exp_strb;

  initial begin
    vecs[0]  = '{1'b1, 16'hFFFF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[1]  = '{1'b1, 16'hFFFF, 4'hF, 1'b1, 4'hF, 1'b1, 2'd0};
    vecs[2]  = '{1'b1, 16'hFFFF, 4'hF, 1'b1, 4'hF, 1'b1, 2'd1};
    vecs[3]  = '{1'b0, 16'hFFFF, 4'hF, 1'b1, 4'hF, 1'b1, 2'd2};
    vecs[4]  = '{1'b0, 16'hFFFF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd3};
    vecs[5]  = '{1'b1, 16'hFFFF, 4'h5, 1'b1, 4'h0, 1'b0, 2'd3};
    vecs[6]  = '{1'b0, 16'hFFFF, 4'h5, 1'b0, 4'hF, 1'b1, 2'd3};
    vecs[7]  = '{1'b0, 16'hFFFF, 4'h5, 1'b0, 4'hA, 1'b1, 2'd3};
    vecs[8]  = '{1'b0, 16'hFFFF, 4'h5, 1'b0, 4'hA, 1'b1, 2'd3};
    vecs[9]  = '{1'b0, 16'hFFFF, 4'h5, 1'b0, 4'hA, 1'b1, 2'd3};
    vecs[10] = '{1'b0, 16'hFFFF, 4'hF, 1'b1, 4'hA, 1'b1, 2'd3};
    vecs[11] = '{1'b0, 16'hFFFF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[12] = '{1'b1, 16'h00FF, 4'h0, 1'b1, 4'h0, 1'b0, 2'd0};
    vecs[13] = '{1'b0, 16'h0000, 4'h0, 1'b0, 4'h3, 1'b1, 2'd0};
    vecs[14] = '{1'b0, 16'h0000, 4'hF, 1'b1, 4'h3, 1'b1, 2'd0};
    vecs[15] = '{1'b1, 16'h0000, 4'hF, 1'b1, 4'h0, 1'b0, 2'd1};
    vecs[16] = '{1'b0, 16'h0000, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2};
    vecs[17] = '{1'b1, 16'hFFFF, 4'hF, 1'b1, 4'h0, 1'b0, 2'd2};
    vecs[18] = '{1'b1, 16'h0000, 4'hF, 1'b1, 4'hF, 1'b1, 2'd2};
    vecs[19] = '{1'b0, 16'h0000, 4'hF, 1'b1, 4'h0, 1'b0, 2'd0};

    rst_i = 1'b1; clear_i = 1'b0; push_valid_i = 1'b0;
    push_data_i = '0; push_strb_i = '0; pop_ready_i = '0;
    exp_data = '0; exp_strb = '0;
    repeat (2) @(posedge clk_i);
    #1 rst_i = 1'b0;
    #1;
    chk("reset_push_ready", 128'(push_ready_o), 128'(1'b1));
    chk("reset_pop_valid", 128'(pop_valid_o), 128'(4'h0));
    chk("reset_busy", 128'(busy_o), 128'(1'b0));
    chk("reset_count", 128'(beat_count_o), 128'(2'd0));
    tick();

    for (int r = 0; r < 20; r++) begin
      push_valid_i = vecs[r].pv;
      push_strb_i  = vecs[r].strb;
      push_data_i  = pat(r);
      pop_ready_i  = vecs[r].rdy;
      #1;
      chk($sformatf("v%0d_push_ready", r), 128'(push_ready_o), 128'(vecs[r].exp_pr));
      chk($sformatf("v%0d_pop_valid", r), 128'(pop_valid_o), 128'(vecs[r].exp_pend));
      chk($sformatf("v%0d_pending", r), 128'(pending_o), 128'(vecs[r].exp_pend));
      chk($sformatf("v%0d_busy", r), 128'(busy_o), 128'(vecs[r].exp_busy));
      chk($sformatf("v%0d_count", r), 128'(beat_count_o), 128'(vecs[r].exp_cnt));
      for (int i = 0; i < 4; i++) begin
        if (vecs[r].exp_pend[i]) begin
          chk($sformatf("v%0d_data%0d", r, i), 128'(pop_data_o[i*32 +: 32]), 128'(exp_data[i*32 +: 32]));
          chk($sformatf("v%0d_strb%0d", r, i), 128'(pop_strb_o[i*4 +: 4]), 128'(exp_strb[i*4 +: 4]));
        end
      end
      if (vecs[r].pv && vecs[r].exp_pr) begin
        exp_data = pat(r);
        exp_strb = vecs[r].strb;
      end
      tick();
    end

    // Consumer 2 stalls: its slice must hold steady and block the next beat.
    push_valid_i = 1'b1; push_strb_i = 16'hFFFF; push_data_i = pat(30); pop_ready_i = 4'b1011;
    #1 chk("stall_first_push_ready", 128'(push_ready_o), 128'(1'b1));
    slice2_data = pat(30);
    tick();
    for (int j = 0; j < 5; j++) begin
      push_data_i = pat(31);
      #1;
      chk($sformatf("stall%0d_push_ready", j), 128'(push_ready_o), 128'(1'b0));
      chk($sformatf("stall%0d_pending", j), 128'(pending_o), 128'((j == 0) ? 4'hF : 4'h4));
      chk($sformatf("stall%0d_slice2", j), 128'(pop_data_o[95:64]), 128'(slice2_data[95:64]));
      tick();
    end
    pop_ready_i = 4'b0100;
    #1 chk("stall_release_push_ready", 128'(push_ready_o), 128'(1'b1));
    tick();
    push_valid_i = 1'b0; pop_ready_i = 4'b1001;
    #1;
    chk("second_beat_pending", 128'(pending_o), 128'(4'hF));
    chk("second_beat_count", 128'(beat_count_o), 128'(2'd1));
    slice2_data = pat(31);
    chk("second_beat_slice1", 128'(pop_data_o[63:32]), 128'(slice2_data[63:32]));
    tick();

    // Soft clear while slices 1 and 2 are still outstanding.
    clear_i = 1'b1; push_valid_i = 1'b1; pop_ready_i = 4'hF;
    #1;
    chk("clear_push_ready", 128'(push_ready_o), 128'(1'b0));
    chk("clear_pending_before", 128'(pending_o), 128'(4'h6));
    tick();
    clear_i = 1'b0; push_valid_i = 1'b0; pop_ready_i = 4'h0;
    #1;
    chk("clear_pending_after", 128'(pending_o), 128'(4'h0));
    chk("clear_busy", 128'(busy_o), 128'(1'b0));
    chk("clear_count", 128'(beat_count_o), 128'(2'd0));
    chk("clear_data", pop_data_o, 128'(0));
    chk("clear_push_ready_after", 128'(push_ready_o), 128'(1'b1));
    tick();

    // Five deliveries wrap the 2-bit counter to 1, then reset lands mid-DIST.
    push_valid_i = 1'b1; push_strb_i = 16'hFFFF; pop_ready_i = 4'hF;
    for (int j = 0; j < 6; j++) begin
      push_data_i = pat(40 + j);
      tick();
    end
    push_valid_i = 1'b0; pop_ready_i = 4'h0;
    #1;
    chk("wrap_count", 128'(beat_count_o), 128'(2'd1));
    chk("wrap_pending", 128'(pending_o), 128'(4'hF));
    chk("wrap_busy", 128'(busy_o), 128'(1'b1));
    #1 rst_i = 1'b1;
    #1;
    chk("async_rst_pop_valid", 128'(pop_valid_o), 128'(4'h0));
    chk("async_rst_push_ready", 128'(push_ready_o), 128'(1'b1));
    chk("async_rst_busy", 128'(busy_o), 128'(1'b0));
    chk("async_rst_count", 128'(beat_count_o), 128'(2'd0));
    tick();
    rst_i = 1'b0;
    tick();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
